// File: rtl/regfile_data_arbiter.sv
// Round-robin arbiter between two requesters on a single-port register file.
// A two-stage read tag pipeline routes returned data; a clear engine zero-fills all entries.
module regfile_data_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_valid,
    input  logic                  a_write,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ready,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_valid,
    input  logic                  b_write,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ready,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    input  logic                  clear_start,
    output logic                  clear_busy,
    output logic                  clear_done,
    output logic [ADDR_WIDTH-1:0] rf_address,
    output logic [DATA_WIDTH-1:0] rf_data_in,
    output logic                  rf_mode,
    input  logic [DATA_WIDTH-1:0] rf_data_out
);

    typedef enum logic {ARB = 1'b0, CLEAR = 1'b1} state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST = '1;

    state_e                state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] rf_address_q, rf_address_d;
    logic [DATA_WIDTH-1:0] rf_data_in_q, rf_data_in_d;
    logic                  rf_mode_q, rf_mode_d;
    logic                  clear_done_q, clear_done_d;
    logic                  tag0_v_q, tag0_v_d, tag0_p_q, tag0_p_d;
    logic                  tag1_v_q, tag1_p_q;
    logic                  a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
    logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic                  a_gnt, b_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB:     if (clear_start) state_d = CLEAR;
            CLEAR:   if (cnt_q == LAST) state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        a_gnt        = 1'b0;
        b_gnt        = 1'b0;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        rf_address_d = rf_address_q;
        rf_data_in_d = rf_data_in_q;
        rf_mode_d    = 1'b0;
        clear_done_d = 1'b0;
        unique case (state_q)
            ARB: begin
                // ptr_q = 0 favours A, 1 favours B
                a_gnt = a_valid && (!b_valid || !ptr_q);
                b_gnt = b_valid && (!a_valid || ptr_q);
                if (a_gnt) begin
                    rf_address_d = a_addr;
                    rf_data_in_d = a_wdata;
                    rf_mode_d    = a_write;
                    ptr_d        = 1'b1;
                end else if (b_gnt) begin
                    rf_address_d = b_addr;
                    rf_data_in_d = b_wdata;
                    rf_mode_d    = b_write;
                    ptr_d        = 1'b0;
                end
            end
            CLEAR: begin
                rf_address_d = cnt_q;
                rf_data_in_d = '0;
                rf_mode_d    = 1'b1;
                cnt_d        = cnt_q + 1'b1;
                clear_done_d = (cnt_q == LAST);
            end
            default: ;
        endcase
    end

    assign tag0_v_d   = (a_gnt && !a_write) || (b_gnt && !b_write);
    assign tag0_p_d   = b_gnt;
    assign a_rvalid_d = tag1_v_q && !tag1_p_q;
    assign b_rvalid_d = tag1_v_q && tag1_p_q;
    assign a_rdata_d  = a_rvalid_d ? rf_data_out : a_rdata_q;
    assign b_rdata_d  = b_rvalid_d ? rf_data_out : b_rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q        <= 1'b0;
            cnt_q        <= '0;
            rf_address_q <= '0;
            rf_data_in_q <= '0;
            rf_mode_q    <= 1'b0;
            clear_done_q <= 1'b0;
            tag0_v_q     <= 1'b0;
            tag0_p_q     <= 1'b0;
            tag1_v_q     <= 1'b0;
            tag1_p_q     <= 1'b0;
            a_rvalid_q   <= 1'b0;
            b_rvalid_q   <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
        end else begin
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            rf_address_q <= rf_address_d;
            rf_data_in_q <= rf_data_in_d;
            rf_mode_q    <= rf_mode_d;
            clear_done_q <= clear_done_d;
            tag0_v_q     <= tag0_v_d;
            tag0_p_q     <= tag0_p_d;
            tag1_v_q     <= tag0_v_q;
            tag1_p_q     <= tag0_p_q;
            a_rvalid_q   <= a_rvalid_d;
            b_rvalid_q   <= b_rvalid_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
        end
    end

    // Grants are combinational, so mask them while reset is held
    assign a_ready    = a_gnt && rst_n;
    assign b_ready    = b_gnt && rst_n;
    assign a_rvalid   = a_rvalid_q;
    assign b_rvalid   = b_rvalid_q;
    assign a_rdata    = a_rdata_q;
    assign b_rdata    = b_rdata_q;
    assign clear_busy = (state_q == CLEAR);
    assign clear_done = clear_done_q;
    assign rf_address = rf_address_q;
    assign rf_data_in = rf_data_in_q;
    assign rf_mode    = rf_mode_q;

endmodule

// File: tb/tb_regfile_data_arbiter.sv
// Bench for regfile_data_arbiter: register-file model, grant/command model,
// and a read scoreboard keyed by due cycle.
module tb_regfile_data_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, a_write, a_ready, a_rvalid;
    logic [3:0]  a_addr;
    logic [15:0] a_wdata, a_rdata;
    logic        b_valid, b_write, b_ready, b_rvalid;
    logic [3:0]  b_addr;
    logic [15:0] b_wdata, b_rdata;
    logic        clear_start, clear_busy, clear_done;
    logic [3:0]  rf_address;
    logic [15:0] rf_data_in, rf_data_out;
    logic        rf_mode;

    regfile_data_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_write(a_write), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_ready(a_ready), .a_rvalid(a_rvalid),
        .a_rdata(a_rdata),
        .b_valid(b_valid), .b_write(b_write), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_ready(b_ready), .b_rvalid(b_rvalid),
        .b_rdata(b_rdata),
        .clear_start(clear_start), .clear_busy(clear_busy),
        .clear_done(clear_done),
        .rf_address(rf_address), .rf_data_in(rf_data_in),
        .rf_mode(rf_mode), .rf_data_out(rf_data_out)
    );

    always #5 clk = ~clk;

    // Register file: latches inputs at an edge, stores a write one edge later
    logic [15:0] mem [16] = '{default: 16'h0000};
    logic [3:0]  lat_addr = 4'h0;
    logic [15:0] lat_data = 16'h0;
    logic        lat_mode = 1'b0;

    always @(posedge clk) begin
        if (lat_mode) mem[lat_addr] <= lat_data;
        lat_addr <= rf_address;
        lat_data <= rf_data_in;
        lat_mode <= rf_mode;
    end

    assign rf_data_out = mem[lat_addr];

    typedef struct {
        bit          port;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        q[$];
    logic [15:0] exp_mem [16];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cycle = 0;
    int          dones = 0;
    bit          ptr_m, busy_m, done_m, n_mode;
    logic [3:0]  cnt_m, m_addr;
    logic [15:0] m_data;
    bit          acc_a, acc_b;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        q.delete();
        ptr_m  = 1'b0;
        busy_m = 1'b0;
        done_m = 1'b0;
        n_mode = 1'b0;
        cnt_m  = 4'h0;
        m_addr = 4'h0;
        m_data = 16'h0;
    endtask

    task automatic cyc();
        bit ea, eb, ev_a, ev_b;
        @(negedge clk);
        ea = !busy_m && a_valid && (!b_valid || !ptr_m);
        eb = !busy_m && b_valid && (!a_valid || ptr_m);
        chk("a_ready", a_ready, ea);
        chk("b_ready", b_ready, eb);
        chk("clear_busy", clear_busy, busy_m);
        acc_a  = ea;
        acc_b  = eb;
        n_mode = 1'b0;
        done_m = 1'b0;
        if (busy_m) begin
            m_addr = cnt_m;
            m_data = 16'h0;
            n_mode = 1'b1;
            if (cnt_m == 4'hF) begin
                busy_m = 1'b0;
                done_m = 1'b1;
            end
            cnt_m = cnt_m + 4'h1;
        end else begin
            if (ea) begin
                m_addr = a_addr;
                m_data = a_wdata;
                n_mode = a_write;
                if (a_write) exp_mem[a_addr] = a_wdata;
                else q.push_back('{1'b0, exp_mem[a_addr], cycle + 3});
                ptr_m = 1'b1;
            end else if (eb) begin
                m_addr = b_addr;
                m_data = b_wdata;
                n_mode = b_write;
                if (b_write) exp_mem[b_addr] = b_wdata;
                else q.push_back('{1'b1, exp_mem[b_addr], cycle + 3});
                ptr_m = 1'b0;
            end
            if (clear_start) begin
                busy_m = 1'b1;
                cnt_m  = 4'h0;
                for (int i = 0; i < 16; i++) exp_mem[i] = 16'h0;
            end
        end
        @(posedge clk);
        cycle++;
        #1;
        chk("rf_mode", rf_mode, n_mode);
        chk("rf_address", rf_address, m_addr);
        chk("rf_data_in", rf_data_in, m_data);
        chk("clear_done", clear_done, done_m);
        if (clear_done === 1'b1) dones++;
        ev_a = q.size() > 0 && q[0].due == cycle && q[0].port == 1'b0;
        ev_b = q.size() > 0 && q[0].due == cycle && q[0].port == 1'b1;
        chk("a_rvalid", a_rvalid, ev_a);
        chk("b_rvalid", b_rvalid, ev_b);
        if (ev_a) chk("a_rdata", a_rdata, q[0].data);
        if (ev_b) chk("b_rdata", b_rdata, q[0].data);
        if (q.size() > 0 && q[0].due <= cycle) void'(q.pop_front());
    endtask

    task automatic req(input bit port, input logic w, input logic [3:0] ad,
                       input logic [15:0] d);
        bit got;
        got = 1'b0;
        if (!port) begin
            a_valid = 1'b1; a_write = w; a_addr = ad; a_wdata = d;
        end else begin
            b_valid = 1'b1; b_write = w; b_addr = ad; b_wdata = d;
        end
        for (int i = 0; i < 40 && !got; i++) begin
            cyc();
            got = port ? acc_b : acc_a;
        end
        if (!got) chk("req_timeout", 32'd0, 32'd1);
        if (!port) a_valid = 1'b0;
        else b_valid = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_a_ready"}, a_ready, 1'b0);
        chk({tag, "_b_ready"}, b_ready, 1'b0);
        chk({tag, "_a_rvalid"}, a_rvalid, 1'b0);
        chk({tag, "_b_rvalid"}, b_rvalid, 1'b0);
        chk({tag, "_a_rdata"}, a_rdata, 16'h0);
        chk({tag, "_b_rdata"}, b_rdata, 16'h0);
        chk({tag, "_busy"}, clear_busy, 1'b0);
        chk({tag, "_done"}, clear_done, 1'b0);
        chk({tag, "_rf_addr"}, rf_address, 4'h0);
        chk({tag, "_rf_din"}, rf_data_in, 16'h0);
        chk({tag, "_rf_mode"}, rf_mode, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got_a, got_b;
        rst_n = 1'b0;
        a_valid = 1'b0; a_write = 1'b0; a_addr = 4'h0; a_wdata = 16'h0;
        b_valid = 1'b0; b_write = 1'b0; b_addr = 4'h0; b_wdata = 16'h0;
        clear_start = 1'b0;
        for (int i = 0; i < 16; i++) exp_mem[i] = 16'h0;
        reset_model();
        #3;
        check_idle_outputs("por");
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Reset with a read in flight and a_valid still high
        a_valid = 1'b1; a_write = 1'b0; a_addr = 4'h0;
        cyc();
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("rst_mid");
        reset_model();
        a_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) cyc();

        // Back-to-back write then read on port A
        req(1'b0, 1'b1, 4'h3, 16'hBEEF);
        req(1'b0, 1'b0, 4'h3, 16'h0000);
        repeat (4) cyc();

        // Contention: both ports reading continuously
        req(1'b0, 1'b1, 4'h1, 16'h0011);
        req(1'b1, 1'b1, 4'h2, 16'h0022);
        a_valid = 1'b1; a_write = 1'b0; a_addr = 4'h1;
        b_valid = 1'b1; b_write = 1'b0; b_addr = 4'h2;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("alt_a", acc_a, (i % 2) == 0);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (4) cyc();

        // Idle after a write: no stray writes
        req(1'b1, 1'b1, 4'h5, 16'h1234);
        repeat (10) cyc();
        req(1'b0, 1'b0, 4'h5, 16'h0000);
        repeat (4) cyc();

        // Full clear after filling with ones; reads queued during the clear
        for (int i = 0; i < 16; i++) req(i[0], 1'b1, i[3:0], 16'hFFFF);
        repeat (3) cyc();
        dones = 0;
        clear_start = 1'b1;
        cyc();
        clear_start = 1'b0;
        a_valid = 1'b1; a_write = 1'b0; a_addr = 4'h0;
        b_valid = 1'b1; b_write = 1'b0; b_addr = 4'hF;
        got_a = 1'b0; got_b = 1'b0;
        for (int i = 0; i < 40 && !(got_a && got_b); i++) begin
            cyc();
            if (acc_a) begin got_a = 1'b1; a_valid = 1'b0; end
            if (acc_b) begin got_b = 1'b1; b_valid = 1'b0; end
        end
        chk("clr_reads_granted", {got_a, got_b}, 2'b11);
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (4) cyc();
        chk("clr_done_count", dones, 1);

        // Clear overlapping a port B read, with a second start while busy
        req(1'b0, 1'b1, 4'h7, 16'h7777);
        dones = 0;
        b_valid = 1'b1; b_write = 1'b0; b_addr = 4'h7;
        clear_start = 1'b1;
        cyc();
        chk("ovl_b_granted", acc_b, 1'b1);
        b_valid = 1'b0;
        clear_start = 1'b0;
        repeat (5) cyc();
        clear_start = 1'b1;
        cyc();
        clear_start = 1'b0;
        repeat (14) cyc();
        chk("ovl_done_count", dones, 1);
        req(1'b1, 1'b0, 4'h7, 16'h0000);
        repeat (4) cyc();
        chk("queue_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
